// File: rtl/region_load_tracker.sv
// Per-region load/OID tracker with a single-slot partial-reconfiguration sequencer.
// Define REGION_TRACKER_ERR_EN to enable the sticky err_underflow flag and cfg range check.
module region_load_tracker #(
    parameter int N_REGIONS         = 4,
    parameter int OPERATOR_ID_WIDTH = 4,
    parameter int QDEPTH            = 16,
    localparam int PNTR_BITS = $clog2(QDEPTH),
    localparam int RB        = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    localparam int W         = OPERATOR_ID_WIDTH + PNTR_BITS
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [RB-1:0]                disp_region,
    input  logic [N_REGIONS-1:0]         cmpl_valid,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [RB-1:0]                cfg_region,
    input  logic [OPERATOR_ID_WIDTH-1:0] cfg_oid,
    output logic                         pr_start,
    output logic [RB-1:0]                pr_region,
    input  logic                         pr_done,
    output logic [N_REGIONS*W-1:0]       region_stats_out,
    output logic                         err_underflow
);

    typedef enum logic [1:0] {IDLE, DRAIN, PR_REQ, PR_WAIT} state_t;

    localparam logic [PNTR_BITS-1:0] LOAD_MAX = '1;

    state_t                       state, state_nxt;
    logic [PNTR_BITS-1:0]         load     [N_REGIONS];
    logic [PNTR_BITS-1:0]         load_nxt [N_REGIONS];
    logic [OPERATOR_ID_WIDTH-1:0] oid      [N_REGIONS];
    logic [OPERATOR_ID_WIDTH-1:0] pend_oid;
    logic [N_REGIONS-1:0]         inc;
    logic [PNTR_BITS-1:0]         disp_load;
    logic                         disp_hit;
    logic                         disp_locked;
    logic                         busy;
    logic                         pr_load_zero;
    logic                         cfg_take;

    assign busy = (state != IDLE);

    always_comb begin
        disp_load = '0;
        disp_hit  = 1'b0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (disp_region == RB'(i)) begin
                disp_load = load[i];
                disp_hit  = 1'b1;
            end
        end
    end

    assign disp_locked = busy && (pr_region == disp_region);
    assign disp_ready  = disp_hit && (disp_load != LOAD_MAX) && !disp_locked;

    // Dispatch and completion in the same cycle cancel; completions at zero clamp.
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            inc[i]      = disp_valid && disp_ready && (disp_region == RB'(i));
            load_nxt[i] = load[i];
            if (inc[i] && !cmpl_valid[i])
                load_nxt[i] = load[i] + PNTR_BITS'(1);
            else if (cmpl_valid[i] && !inc[i] && (load[i] != '0))
                load_nxt[i] = load[i] - PNTR_BITS'(1);
        end
    end

    always_comb begin
        pr_load_zero = 1'b0;
        for (int i = 0; i < N_REGIONS; i++)
            if (pr_region == RB'(i))
                pr_load_zero = (load_nxt[i] == '0);
    end

`ifdef REGION_TRACKER_ERR_EN
    logic                 cfg_oor;
    logic [N_REGIONS-1:0] uf;
    logic                 err_q;

    if (N_REGIONS < (1 << RB)) begin : g_oor
        assign cfg_oor = (cfg_region >= RB'(N_REGIONS));
    end else begin : g_no_oor
        assign cfg_oor = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++)
            uf[i] = cmpl_valid[i] && !inc[i] && (load[i] == '0);
    end

    assign cfg_take = (state == IDLE) && cfg_valid && !cfg_oor;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            err_q <= 1'b0;
        else if ((|uf) || ((state == IDLE) && cfg_valid && cfg_oor))
            err_q <= 1'b1;
    end

    assign err_underflow = err_q;
`else
    assign cfg_take      = (state == IDLE) && cfg_valid;
    assign err_underflow = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_take)     state_nxt = DRAIN;
            DRAIN:   if (pr_load_zero) state_nxt = PR_REQ;
            PR_REQ:                    state_nxt = PR_WAIT;
            PR_WAIT: if (pr_done)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        pr_start  = 1'b0;
        unique case (state)
            IDLE:    cfg_ready = 1'b1;
            PR_REQ:  pr_start  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pr_region <= '0;
            pend_oid  <= '0;
            for (int i = 0; i < N_REGIONS; i++) begin
                load[i] <= '0;
                oid[i]  <= '0;
            end
        end else begin
            if (cfg_take) begin
                pr_region <= cfg_region;
                pend_oid  <= cfg_oid;
            end
            for (int i = 0; i < N_REGIONS; i++) begin
                load[i] <= load_nxt[i];
                if ((state == PR_WAIT) && pr_done && (pr_region == RB'(i)))
                    oid[i] <= pend_oid;
            end
        end
    end

    // A region under reconfiguration advertises full load so nobody targets it.
    for (genvar g = 0; g < N_REGIONS; g++) begin : g_stats
        logic locked;
        assign locked = busy && (pr_region == RB'(g));
        assign region_stats_out[g*W +: W] =
            {oid[g], (locked ? LOAD_MAX : load[g])};
    end

endmodule
